// File: rtl/home_pkg.sv
// ============================================================================
// Module  : home_pkg
// Brief   : Shared state encoding, event indices and display codes for the
//           home alert scheduler.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package home_pkg;

    localparam int NUM_EV = 6;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_SHOW   = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_SELECT = S_SELECT,
        ST_SHOW   = S_SHOW,
        ST_GAP    = S_GAP
    } state_t;

    localparam logic [2:0] EV_FDOOR  = 3'd0;
    localparam logic [2:0] EV_RDOOR  = 3'd1;
    localparam logic [2:0] EV_FIRE   = 3'd2;
    localparam logic [2:0] EV_WINDOW = 3'd3;
    localparam logic [2:0] EV_COLD   = 3'd4;
    localparam logic [2:0] EV_HOT    = 3'd5;

    localparam logic [2:0] CODE_NONE   = 3'd0;
    localparam logic [2:0] CODE_FDOOR  = 3'd1;
    localparam logic [2:0] CODE_RDOOR  = 3'd2;
    localparam logic [2:0] CODE_FIRE   = 3'd3;
    localparam logic [2:0] CODE_WINDOW = 3'd4;
    localparam logic [2:0] CODE_COLD   = 3'd5;
    localparam logic [2:0] CODE_HOT    = 3'd6;

    function automatic logic [2:0] ev_code(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

    // Actuator bus is bit-reversed relative to the request bus.
    function automatic logic [5:0] ev_act(input logic [2:0] idx);
        return 6'b100000 >> idx;
    endfunction

    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_EV) begin
            s = s - NUM_EV;
        end
        return 3'(s);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alert_scheduler_rr_pick6.sv
// ============================================================================
// Module  : rr_pick6
// Brief   : Combinational picker over six pending events: optional fire
//           priority, otherwise round-robin starting after the last grant.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick6
    import home_pkg::*;
(
    input  logic [5:0] pending,
    input  logic [2:0] last,
    input  logic       fire_first,
    output logic [2:0] grant,
    output logic       valid
);

    always_comb begin
        grant = 3'd0;
        valid = 1'b0;
        // Walk furthest-first so the nearest pending index is the final write.
        for (int k = NUM_EV; k >= 1; k--) begin
            if (pending[wrap_idx(last, k)]) begin
                grant = wrap_idx(last, k);
                valid = 1'b1;
            end
        end
        if (fire_first && pending[EV_FIRE]) begin
            grant = EV_FIRE;
            valid = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alert_scheduler.sv
// ============================================================================
// Module  : alert_scheduler
// Brief   : Shares one status display and six actuators among six sensor
//           events; fire first, rest round-robin, dwell-limited grants.
//           Optional macro FIRE_PREEMPT_EN lets a pending fire cut a grant.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alert_scheduler
    import home_pkg::*;
#(
    parameter int DWELL = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [5:0] req,
    input  logic       ack,
    output logic [2:0] display,
    output logic [5:0] act,
    output logic [5:0] pending,
    output logic       busy
);

    localparam int CNT_W = $clog2(DWELL + 1);

    state_t           state, state_nxt;
    logic [5:0]       mask, mask_nxt, pending_nxt, clr_vec;
    logic [2:0]       gnt, gnt_nxt, rr_last, rr_last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       display_nxt;
    logic [5:0]       act_nxt;
    logic             busy_nxt;
    logic [2:0]       pick;
    logic             pick_valid;
    logic             preempt;

    rr_pick6 u_pick (
        .pending    (pending),
        .last       (rr_last),
        .fire_first (1'b1),
        .grant      (pick),
        .valid      (pick_valid)
    );

`ifdef FIRE_PREEMPT_EN
    assign preempt = (gnt != EV_FIRE) && pending[EV_FIRE];
`else
    assign preempt = 1'b0;
`endif

    // Acknowledge retires the shown event and masks it until its request falls.
    assign clr_vec     = (state == ST_SHOW && ack) ? (6'b000001 << gnt) : 6'b000000;
    assign pending_nxt = (pending | (req & ~mask)) & ~clr_vec;
    assign mask_nxt    = (mask | clr_vec) & req;

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        rr_last_nxt = rr_last;
        cnt_nxt     = cnt;
        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (pick_valid) begin
                    gnt_nxt   = pick;
                    cnt_nxt   = CNT_W'(DWELL - 1);
                    state_nxt = ST_SHOW;
                    if (pick != EV_FIRE) begin
                        rr_last_nxt = pick;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHOW: begin
                if (ack) begin
                    state_nxt = ST_GAP;
                end else if (preempt) begin
                    state_nxt = ST_SELECT;
                end else if (cnt == '0) begin
                    state_nxt = ST_GAP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_nxt = (|pending) ? ST_SELECT : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        display_nxt = (state_nxt == ST_SHOW) ? ev_code(gnt_nxt) : CODE_NONE;
        act_nxt     = (state_nxt == ST_SHOW) ? ev_act(gnt_nxt) : 6'b000000;
        busy_nxt    = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= ST_IDLE;
            gnt     <= EV_FDOOR;
            rr_last <= EV_HOT;
            cnt     <= '0;
            mask    <= 6'b000000;
            pending <= 6'b000000;
            display <= CODE_NONE;
            act     <= 6'b000000;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            rr_last <= rr_last_nxt;
            cnt     <= cnt_nxt;
            mask    <= mask_nxt;
            pending <= pending_nxt;
            display <= display_nxt;
            act     <= act_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alert_scheduler.sv
// ============================================================================
// Module  : tb_alert_scheduler
// Brief   : Directed self-checking bench for alert_scheduler (DWELL=4) with an
//           event-level reference model compared every cycle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alert_scheduler;

    localparam int DWELL = 4;
`ifdef FIRE_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic       Clk   = 1'b0;
    logic       Rst_n = 1'b0;
    logic [5:0] req   = 6'b000000;
    logic       ack   = 1'b0;
    logic [2:0] display;
    logic [5:0] act;
    logic [5:0] pending;
    logic       busy;

    alert_scheduler #(.DWELL(DWELL)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .req     (req),
        .ack     (ack),
        .display (display),
        .act     (act),
        .pending (pending),
        .busy    (busy)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: what is on screen, how long it has left, which
    // events are outstanding and which are muted until their request falls.
    localparam int IDLE = 0, CHOOSING = 1, SHOWING = 2, COOLING = 3;
    int  mode = IDLE;
    int  cur  = 0;
    int  left = 0;
    int  last = 5;
    bit  m_pend [6];
    bit  m_mute [6];

    function automatic int next_event(input bit p [6], input int from);
        int i;
        if (p[2]) return 2;
        for (int k = 1; k <= 6; k++) begin
            i = (from + k) % 6;
            if (p[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit any_set(input bit p [6]);
        for (int i = 0; i < 6; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mode = IDLE; cur = 0; left = 0; last = 5;
        for (int i = 0; i < 6; i++) begin m_pend[i] = 1'b0; m_mute[i] = 1'b0; end
    endtask

    task automatic model_step();
        bit old [6];
        bit acked;
        int g;
        old   = m_pend;
        acked = ack && (mode == SHOWING);
        for (int i = 0; i < 6; i++) begin
            if (req[i] && !m_mute[i]) m_pend[i] = 1'b1;
        end
        if (acked) begin
            m_pend[cur] = 1'b0;
            m_mute[cur] = 1'b1;
        end
        for (int i = 0; i < 6; i++) if (!req[i]) m_mute[i] = 1'b0;
        case (mode)
            IDLE:     if (any_set(old)) mode = CHOOSING;
            CHOOSING: begin
                g = next_event(old, last);
                if (g < 0) mode = IDLE;
                else begin
                    cur = g; left = DWELL; mode = SHOWING;
                    if (g != 2) last = g;
                end
            end
            SHOWING: begin
                if (acked) mode = COOLING;
                else if (PREEMPT && cur != 2 && old[2]) mode = CHOOSING;
                else if (left == 1) mode = COOLING;
                else left = left - 1;
            end
            default:  mode = any_set(old) ? CHOOSING : IDLE;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clk or negedge Rst_n);
            if (!Rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        logic [5:0] e_pend;
        forever begin
            @(negedge Clk);
            for (int i = 0; i < 6; i++) e_pend[i] = m_pend[i];
            chk("model_display", display, (mode == SHOWING) ? 3'(cur + 1) : 3'd0);
            chk("model_act", act, (mode == SHOWING) ? (6'b100000 >> cur) : 6'b000000);
            chk("model_pending", pending, e_pend);
            chk("model_busy", busy, (mode != IDLE) ? 1'b1 : 1'b0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #3;
    endtask

    task automatic wait_show(input string name, input logic [2:0] code);
        int n;
        n = 0;
        while (display == 3'd0 && n < 30) begin
            tick(1);
            n++;
        end
        chk(name, display, code);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_display", display, 3'd0);
        chk("rst_pending", pending, 6'd0);
        chk("rst_busy", busy, 1'b0);
        Rst_n = 1'b1;

        // 1: single pulse, dwell expiry and redisplay, then ack
        req = 6'b000001; tick(1); req = 6'b000000;
        chk("t1_pend", pending, 6'b000001);
        tick(1);
        chk("t1_sel_disp", display, 3'd0);
        chk("t1_sel_busy", busy, 1'b1);
        tick(1);
        chk("t1_show", display, 3'd1);
        chk("t1_act", act, 6'b100000);
        tick(3);
        chk("t1_show_last", display, 3'd1);
        tick(1);
        chk("t1_gap", display, 3'd0);
        tick(1);
        chk("t1_select", display, 3'd0);
        tick(1);
        chk("t1_redisplay", display, 3'd1);
        do_ack();
        chk("t1_ack_disp", display, 3'd0);
        chk("t1_ack_pend", pending, 6'd0);
        tick(1);
        chk("t1_idle_busy", busy, 1'b0);

        // 2: round-robin order from a fresh reset
        Rst_n = 1'b0; tick(1); Rst_n = 1'b1;
        req = 6'b101001; tick(1); req = 6'b000000;
        wait_show("t2_first", 3'd1); do_ack();
        wait_show("t2_second", 3'd4); do_ack();
        wait_show("t2_third", 3'd6); do_ack();
        tick(3);
        chk("t2_done_busy", busy, 1'b0);

        // 3: fire arrives while window is shown
        req = 6'b001000; tick(1); req = 6'b000000;
        wait_show("t3_window", 3'd4);
        req = 6'b000100; tick(1); req = 6'b000000;
        chk("t3_still4", display, 3'd4);
        chk("t3_pend", pending, 6'b001100);
`ifdef FIRE_PREEMPT_EN
        tick(1);
        chk("t3_pre_gap", display, 3'd0);
        tick(1);
        chk("t3_pre_fire", display, 3'd3);
        chk("t3_pre_pend", pending, 6'b001100);
`else
        tick(2);
        chk("t3_full_dwell", display, 3'd4);
        tick(2);
        chk("t3_gap", display, 3'd0);
        tick(1);
        chk("t3_fire", display, 3'd3);
`endif
        do_ack();
        wait_show("t3_window_back", 3'd4); do_ack();
        tick(3);

        // 4: held request is muted after ack until it falls and rises
        req = 6'b000010;
        wait_show("t4_show", 3'd2);
        do_ack();
        chk("t4_pend_clr", pending[1], 1'b0);
        tick(4);
        chk("t4_pend_held", pending[1], 1'b0);
        chk("t4_idle", busy, 1'b0);
        req = 6'b000000; tick(1);
        req = 6'b000010; tick(1);
        chk("t4_rearm", pending[1], 1'b1);
        req = 6'b000000;
        wait_show("t4_reshow", 3'd2); do_ack();
        tick(3);

        // 5: ack coincident with dwell expiry
        req = 6'b010000; tick(1); req = 6'b000000;
        wait_show("t5_show", 3'd5);
        tick(3);
        chk("t5_last_cycle", display, 3'd5);
        do_ack();
        chk("t5_pend", pending, 6'd0);
        tick(4);
        chk("t5_no_redisplay", display, 3'd0);
        chk("t5_busy", busy, 1'b0);

        // 6: asynchronous reset mid-grant, then search restarts at index 0
        req = 6'b001000; tick(1); req = 6'b000000;
        wait_show("t6_show", 3'd4);
        tick(1);
        Rst_n = 1'b0;
        #1;
        chk("t6_rst_display", display, 3'd0);
        chk("t6_rst_act", act, 6'd0);
        chk("t6_rst_pending", pending, 6'd0);
        chk("t6_rst_busy", busy, 1'b0);
        tick(1);
        Rst_n = 1'b1;
        req = 6'b100010; tick(1); req = 6'b000000;
        wait_show("t6_resume", 3'd2); do_ack();
        wait_show("t6_resume_next", 3'd6); do_ack();
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
